// File: rtl/hazard_controller_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline control unit.
// Contents: state_t (RUN, LOAD_STALL, FLUSH), REG_ADDR_W, PC_WIDTH_DEF, ZERO_REG.
package pipeline_pkg;
    typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;
    localparam int REG_ADDR_W = 5;
    localparam int PC_WIDTH_DEF = 11;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline <-> hazard controller signal bundle.
// ID/EX/MEM status flows pipeline -> controller.
// PC, IF/ID and ID/EX controls plus the statistics counters flow back to the pipeline.
// Modport master: the controller. Modport slave: the pipeline.
interface hazard_controller_if
    import pipeline_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_branch_taken;
    logic [PC_WIDTH-1:0]   id_branch_target;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  mem_busy;
    logic                  pc_write;
    logic                  pc_src;
    logic [PC_WIDTH-1:0]   pc_target;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  id_ex_bubble;
    logic [15:0]           stall_count;
    logic [15:0]           flush_count;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken, id_branch_target,
               ex_mem_read, ex_dest, mem_busy,
        output pc_write, pc_src, pc_target, if_id_write, if_id_flush, id_ex_write,
               id_ex_bubble, stall_count, flush_count
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken, id_branch_target,
               ex_mem_read, ex_dest, mem_busy,
        input  pc_write, pc_src, pc_target, if_id_write, if_id_flush, id_ex_write,
               id_ex_bubble, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones.
// Ports: clock, reset (sync, active-high), inc (count enable), count (current value).
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clock)
        if (reset)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and memory-wait freeze control.
// Ports:
// - clock, reset: sync, active-high.
// - bus (master modport): ID/EX/MEM status in.
// - bus: PC/IF-ID/ID-EX controls and saturating stall/flush counters out.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int PC_WIDTH     = PC_WIDTH_DEF
)(
    input  logic                 clock,
    input  logic                 reset,
    hazard_controller_if.master  bus
);
    state_t     state, nxt;
    logic [2:0] cnt, cnt_n;
    logic       hz;

    // A load in EX feeding a register actually read in ID.
    // LOAD_STALL masks it because the load has advanced by then.
    assign hz = bus.ex_mem_read && bus.ex_dest != ZERO_REG && state != LOAD_STALL &&
                ((bus.id_uses_rs && bus.id_rs == bus.ex_dest) ||
                 (bus.id_uses_rt && bus.id_rt == bus.ex_dest));

    always_ff @(posedge clock)
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
        end

    always_comb begin
        nxt              = state;
        cnt_n            = cnt;
        bus.pc_write     = 1'b1;
        bus.pc_src       = 1'b0;
        bus.pc_target    = '0;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_write  = 1'b1;
        bus.id_ex_bubble = 1'b0;
        if (bus.mem_busy) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_write = 1'b0;
        end else if (hz) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
            bus.if_id_flush  = state == FLUSH;
            nxt              = state == FLUSH ? FLUSH : LOAD_STALL;
        end else if (state == FLUSH) begin
            // The branch cycle is the first flush cycle, so FLUSH itself lasts FLUSH_CYCLES-1 cycles.
            bus.if_id_flush = 1'b1;
            cnt_n           = cnt - 3'd1;
            nxt             = cnt <= 3'd1 ? RUN : FLUSH;
        end else if (bus.id_branch_taken) begin
            bus.pc_src      = 1'b1;
            bus.pc_target   = bus.id_branch_target;
            bus.if_id_flush = 1'b1;
            cnt_n           = 3'(FLUSH_CYCLES - 1);
            nxt             = FLUSH_CYCLES == 1 ? RUN : FLUSH;
        end else begin
            nxt = RUN;
        end
    end

    sat_counter16 u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!bus.pc_write),
        .count (bus.stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (bus.pc_src),
        .count (bus.flush_count)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller with FLUSH_CYCLES=2.
module tb_hazard_controller;
    import pipeline_pkg::*;

    // Control word layout: {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, pc_target}
    typedef logic [16:0] ctl_t;
    typedef struct packed {
        ctl_t        c;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    localparam ctl_t D  = {6'b101010, 11'd0};
    localparam ctl_t S  = {6'b000011, 11'd0};
    localparam ctl_t SF = {6'b000111, 11'd0};
    localparam ctl_t B  = {6'b000000, 11'd0};
    localparam ctl_t F  = {6'b101110, 11'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_sc = '0;
    logic [15:0] exp_fc = '0;
    exp_t        q[$];

    hazard_controller_if #(.PC_WIDTH(11)) bus ();

    hazard_controller #(.FLUSH_CYCLES(2), .PC_WIDTH(11)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t br(input logic [10:0] t);
        return {6'b111110, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clr();
        bus.id_rs            = '0;
        bus.id_rt            = '0;
        bus.id_uses_rs       = 1'b0;
        bus.id_uses_rt       = 1'b0;
        bus.id_branch_taken  = 1'b0;
        bus.id_branch_target = '0;
        bus.ex_mem_read      = 1'b0;
        bus.ex_dest          = '0;
        bus.mem_busy         = 1'b0;
    endtask

    task automatic load_use();
        bus.ex_mem_read = 1'b1;
        bus.ex_dest     = 5'd8;
        bus.id_rs       = 5'd8;
        bus.id_uses_rs  = 1'b1;
    endtask

    task automatic branch(input logic [10:0] t);
        bus.id_branch_taken  = 1'b1;
        bus.id_branch_target = t;
    endtask

    // Queue this cycle's expectation, advance the bench's counter model, move to the next cycle.
    task automatic step(input ctl_t e);
        q.push_back({e, exp_sc, exp_fc});
        if (!e[16] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        if (e[15] && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl", {15'd0, bus.pc_write, bus.pc_src, bus.if_id_write, bus.if_id_flush,
                        bus.id_ex_write, bus.id_ex_bubble, bus.pc_target}, {15'd0, e.c});
            chk("stall_count", {16'd0, bus.stall_count}, {16'd0, e.sc});
            chk("flush_count", {16'd0, bus.flush_count}, {16'd0, e.fc});
        end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(D);
        load_use();
        step(S);
        step(D);
        clr();
        step(D);
        bus.ex_mem_read = 1'b1;
        bus.id_rs       = 5'd0;
        bus.id_uses_rs  = 1'b1;
        step(D);
        bus.id_uses_rs  = 1'b0;
        bus.ex_dest     = 5'd9;
        bus.id_rt       = 5'd9;
        step(D);
        bus.id_uses_rt  = 1'b1;
        step(S);
        clr();
        step(D);
        branch(11'h1A4);
        step(br(11'h1A4));
        bus.id_branch_target = 11'h055;
        step(F);
        clr();
        step(D);
        load_use();
        branch(11'h0F0);
        step(S);
        step(br(11'h0F0));
        clr();
        step(F);
        step(D);
        branch(11'h0AA);
        step(br(11'h0AA));
        clr();
        load_use();
        step(SF);
        clr();
        step(F);
        step(D);
        branch(11'h123);
        step(br(11'h123));
        clr();
        bus.mem_busy = 1'b1;
        repeat (3) step(B);
        bus.mem_busy = 1'b0;
        step(F);
        step(D);
        bus.mem_busy = 1'b1;
        branch(11'h456);
        step(B);
        bus.mem_busy = 1'b0;
        step(br(11'h456));
        clr();
        step(F);
        branch(11'h7FF);
        step(br(11'h7FF));
        clr();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
        end
        exp_sc = 16'hFFFF;
        repeat (2) step(B);
        bus.mem_busy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sc = '0;
        exp_fc = '0;
        step(D);
        branch(11'h321);
        step(br(11'h321));
        clr();
        step(F);
        step(D);
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control unit for the 5-stage core. Watches the instruction in ID, the instruction in EX and the memory stage's busy flag, and drives the write enables, flushes and bubbles of the PC, IF/ID and ID/EX registers. It also selects the next PC on a taken branch. It owns load-use stalls, branch flushes and memory-wait freezes, and keeps saturating stall and flush statistics.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a taken branch (1..7).
- PC_WIDTH, 11: program counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  ID-stage source register, instruction[25:21]
- id_rt  in  5  ID-stage source register, instruction[20:16]
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_branch_taken  in  1  branch or jump in ID resolved taken
- id_branch_target  in  PC_WIDTH  destination address for the taken branch or jump
- ex_mem_read  in  1  EX instruction is a load
- ex_dest  in  5  EX destination register
- mem_busy  in  1  data memory not ready; freeze the pipeline
- pc_write  out  1  PC register enable
- pc_src  out  1  1 = load pc_target into PC
- pc_target  out  PC_WIDTH  next PC when pc_src=1
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  ID/EX loads all-zero control
- stall_count  out  16  cycles with pc_write=0, saturating
- flush_count  out  16  taken branches accepted, saturating

## Operation
- States: RUN, LOAD_STALL, FLUSH. The state register resets to RUN, and the flush counter resets to 0.
- Control outputs are combinational from the current state and inputs. The counters are registered.
- Default values in RUN: pc_write=1, if_id_write=1, id_ex_write=1, and all other control outputs 0. pc_target outputs 0 unless pc_src=1.
- Load-use hazard (hz) is true when all of the following hold:
  - ex_mem_read=1
  - ex_dest≠0
  - (id_uses_rs and id_rs==ex_dest) or (id_uses_rt and id_rt==ex_dest)
- Priority, evaluated every cycle: mem_busy > hz > id_branch_taken.
- mem_busy=1, in any state:
  - pc_write, if_id_write and id_ex_write are all 0.
  - Flush and bubble outputs are 0, and pc_src=0.
  - The state and the flush counter hold.
- RUN with hz:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Next state is LOAD_STALL.
  - If a branch is also taken that cycle, it is ignored and re-evaluated next cycle.
- RUN with id_branch_taken and no hz:
  - pc_src=1, pc_target=id_branch_target, if_id_flush=1.
  - Load the flush counter with FLUSH_CYCLES-1.
  - Next state is FLUSH, or RUN if FLUSH_CYCLES=1.
  - flush_count increments.
- LOAD_STALL:
  - Behaves as RUN, but hz detection is suppressed.
  - Branches are accepted exactly as in RUN.
  - Next state is RUN, or FLUSH on an accepted branch.
- FLUSH:
  - if_id_flush=1, and id_branch_taken is ignored.
  - hz still stalls but does not change the state.
  - The counter decrements each cycle that is neither mem_busy nor hz.
  - Return to RUN when the counter is 0 on such a cycle.
- Counters:
  - stall_count increments in every cycle with pc_write=0, including mem_busy cycles.
  - Both counters saturate at 16'hFFFF.

## Timing
- Zero-latency control: a hazard is flagged in the same cycle as its inputs.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs FLUSH_CYCLES flush cycles, plus any mem_busy or hz cycles that occur inside the window.
- Reset mid-flush or mid-stall: the next cycle is RUN with default outputs, and both counters are 0.
- Counter updates are visible the cycle after the triggering cycle.

## Structure
- Shared package pipeline_pkg holds:
  - the state enum (RUN, LOAD_STALL, FLUSH)
  - REG_ADDR_W=5
  - PC_WIDTH default
  - ZERO_REG=5'd0
- One sub-module, sat_counter16: a 16-bit counter with increment enable, saturation at all-ones and synchronous reset. It is instantiated twice.
- Hazard comparison and next-state logic are inline.

## Test plan
- Load-use:
  - Stimulus: ex_mem_read=1, ex_dest=5'd8, id_rs=5'd8, id_uses_rs=1.
  - Response: one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then defaults even though the inputs persist. stall_count=1.
- Register 0 and unused operands:
  - Stimulus: ex_dest=0 with matching id_rs. Separately, id_rt match with id_uses_rt=0.
  - Response: no stall in either case.
- Branch with FLUSH_CYCLES=2:
  - Stimulus: id_branch_taken=1, target=11'h1A4.
  - Response: pc_src=1 and pc_target=11'h1A4 for one cycle, if_id_flush=1 for 2 cycles, flush_count=1. A second taken branch during FLUSH is ignored.
- Simultaneous hz and branch:
  - Response: the stall wins and pc_src=0. The next cycle, the branch is accepted with pc_src=1.
- mem_busy held 3 cycles in the middle of FLUSH:
  - Response: all enables are 0 for those 3 cycles and the flush window extends by 3. stall_count=3.
- Saturation and reset:
  - Stimulus: force 70000 mem_busy cycles, then pulse reset in FLUSH.
  - Response: stall_count holds 16'hFFFF until the reset. After the reset, state is RUN and both counters are 0.
